// File: rtl/pll_reconfig_seq.sv
// Runtime reconfiguration sequencer for one PLL: settles and validates a new
// {MUL,DIV,OE,BP} request, then walks gate/bypass/load/lock/unbypass/ungate.
module pll_reconfig_seq #(
    parameter logic [7:0] DEF_MUL    = 8'd46,
    parameter logic [7:0] DEF_DIV    = 8'h22,
    parameter logic       DEF_OE     = 1'b1,
    parameter logic       DEF_BP     = 1'b0,
    parameter logic [7:0] M_MIN      = 8'd8,
    parameter int         SETTLE_CYC = 256,
    parameter int         GATE_CYC   = 16,
    parameter int         LOCK_CYC   = 12500,
    parameter int         RST_CYC    = 64,
    parameter int         CNT_W      = 16
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic [7:0] cfg_mul,
    input  logic [7:0] cfg_div,
    input  logic       cfg_oe,
    input  logic       cfg_bp,
    output logic [7:0] pll_mul,
    output logic [7:0] pll_div,
    output logic       pll_oe,
    output logic       pll_bp,
    output logic       rst_hold_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SETTLE = 4'd1;
    localparam logic [3:0] S_APPLY  = 4'd2;
    localparam logic [3:0] S_GATE   = 4'd3;
    localparam logic [3:0] S_BYP    = 4'd4;
    localparam logic [3:0] S_LOAD   = 4'd5;
    localparam logic [3:0] S_LOCK   = 4'd6;
    localparam logic [3:0] S_UNBYP  = 4'd7;
    localparam logic [3:0] S_UNGATE = 4'd8;
    localparam logic [3:0] S_RLS    = 4'd9;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);

    // Packed setting layout: [17:10] mul, [9:2] div, [1] oe, [0] bp
    localparam logic [17:0] DEF_CFG = {DEF_MUL, DEF_DIV, DEF_OE, DEF_BP};

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_pll_mul;
    logic [7:0]       r_pll_div;
    logic             r_pll_oe;
    logic             r_pll_bp;
    logic             r_rst_hold_n;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [17:0]      r_app;
    logic [17:0]      r_tgt;
    logic [17:0]      r_rej;
    logic             r_rej_vld;
    logic [17:0]      r_cfg_prev;

    logic [17:0]      w_cfg;
    logic             w_eq_app;
    logic             w_eq_rej;
    logic             w_stable;
    logic             w_bad;
    logic             w_ctl_only;

    assign w_cfg      = {cfg_mul, cfg_div, cfg_oe, cfg_bp};
    assign w_eq_app   = (w_cfg == r_app);
    assign w_eq_rej   = r_rej_vld && (w_cfg == r_rej);
    assign w_stable   = (w_cfg == r_cfg_prev);
    assign w_bad      = (cfg_div[4:0] == 5'd0) || (cfg_mul < M_MIN);
    assign w_ctl_only = (w_cfg[17:2] == r_app[17:2]);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            // Reset lands in LOCK so the first lock wait doubles as power-on
            r_state      <= S_LOCK;
            r_cnt        <= '0;
            r_pll_mul    <= DEF_MUL;
            r_pll_div    <= DEF_DIV;
            r_pll_oe     <= 1'b0;
            r_pll_bp     <= 1'b1;
            r_rst_hold_n <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_app        <= DEF_CFG;
            r_tgt        <= DEF_CFG;
            r_rej        <= '0;
            r_rej_vld    <= 1'b0;
            r_cfg_prev   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_cfg_prev <= w_cfg;
            case (r_state)
                S_IDLE: begin
                    r_busy       <= 1'b0;
                    r_rst_hold_n <= 1'b1;
                    r_pll_mul    <= r_app[17:10];
                    r_pll_div    <= r_app[9:2];
                    r_pll_oe     <= r_app[1];
                    r_pll_bp     <= r_app[0];
                    r_cnt        <= '0;
                    if (!w_eq_app && !w_eq_rej)
                        r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!w_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_cnt <= '0;
                        if (w_eq_app) begin
                            r_state <= S_IDLE;
                        end else if (w_bad) begin
                            r_rej     <= w_cfg;
                            r_rej_vld <= 1'b1;
                            r_err     <= 1'b1;
                            r_state   <= S_IDLE;
                        end else if (w_ctl_only) begin
                            r_tgt   <= w_cfg;
                            r_state <= S_APPLY;
                        end else begin
                            r_tgt        <= w_cfg;
                            r_busy       <= 1'b1;
                            r_pll_oe     <= 1'b0;
                            r_rst_hold_n <= 1'b0;
                            r_state      <= S_GATE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_APPLY: begin
                    r_pll_oe  <= r_tgt[1];
                    r_pll_bp  <= r_tgt[0];
                    r_app     <= r_tgt;
                    r_done    <= 1'b1;
                    r_err     <= 1'b0;
                    r_rej_vld <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_GATE: begin
                    if (r_cnt == GATE_LAST) begin
                        r_cnt    <= '0;
                        r_pll_bp <= 1'b1;
                        r_state  <= S_BYP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BYP: begin
                    if (r_cnt == GATE_LAST) begin
                        r_cnt     <= '0;
                        r_pll_mul <= r_tgt[17:10];
                        r_pll_div <= r_tgt[9:2];
                        r_state   <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_LOCK;
                end
                S_LOCK: begin
                    if (r_cnt == LOCK_LAST) begin
                        r_cnt    <= '0;
                        r_pll_bp <= r_tgt[0];
                        r_state  <= S_UNBYP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_UNBYP: begin
                    if (r_cnt == GATE_LAST) begin
                        r_cnt    <= '0;
                        r_pll_oe <= r_tgt[1];
                        r_state  <= S_UNGATE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_UNGATE: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt        <= '0;
                        r_rst_hold_n <= 1'b1;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_app        <= r_tgt;
                        r_err        <= 1'b0;
                        r_rej_vld    <= 1'b0;
                        r_state      <= S_RLS;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RLS: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pll_mul    = r_pll_mul;
    assign pll_div    = r_pll_div;
    assign pll_oe     = r_pll_oe;
    assign pll_bp     = r_pll_bp;
    assign rst_hold_n = r_rst_hold_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq with short timing parameters and a
// request-level reference model of the applied/rejected/err state.
module tb_pll_reconfig_seq;

    localparam int SETTLE = 16;
    localparam int GATE   = 4;
    localparam int LOCK   = 100;
    localparam int RSTC   = 8;

    // Offsets from the GATE-entry cycle of a full sequence
    localparam int G_BYP    = GATE;
    localparam int G_LOAD   = 2 * GATE;
    localparam int G_UNBYP  = 2 * GATE + 1 + LOCK;
    localparam int G_UNGATE = G_UNBYP + GATE;
    localparam int G_RLS    = G_UNGATE + RSTC;
    localparam int T_DETECT = SETTLE + 1;

    localparam logic [17:0] DEF_CFG = {8'd46, 8'h22, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] cfg_mul, cfg_div;
    logic       cfg_oe, cfg_bp;
    logic [7:0] pll_mul, pll_div;
    logic       pll_oe, pll_bp, rst_hold_n, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int low_cnt = 0;

    logic [17:0] m_app;
    logic [17:0] m_rej;
    logic        m_rej_vld;
    logic        m_err;

    pll_reconfig_seq #(
        .DEF_MUL(8'd46), .DEF_DIV(8'h22), .DEF_OE(1'b1), .DEF_BP(1'b0),
        .M_MIN(8'd8), .SETTLE_CYC(SETTLE), .GATE_CYC(GATE),
        .LOCK_CYC(LOCK), .RST_CYC(RSTC), .CNT_W(16)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .cfg_mul(cfg_mul), .cfg_div(cfg_div), .cfg_oe(cfg_oe), .cfg_bp(cfg_bp),
        .pll_mul(pll_mul), .pll_div(pll_div), .pll_oe(pll_oe), .pll_bp(pll_bp),
        .rst_hold_n(rst_hold_n), .busy(busy), .done(done), .err(err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (aresetn) begin
            if (done === 1'b1) done_cnt <= done_cnt + 1;
            if (rst_hold_n === 1'b0) low_cnt <= low_cnt + 1;
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_hold_low(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rst_hold_n === 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic set_cfg(input logic [17:0] c);
        {cfg_mul, cfg_div, cfg_oe, cfg_bp} = c;
    endtask

    task automatic test_reset;
        logic [20:0] got, exp;
        set_cfg(DEF_CFG);
        aresetn = 1'b0;
        wait_cyc(3);
        got = {pll_mul, pll_div, pll_oe, pll_bp, rst_hold_n, busy, done};
        exp = {8'd46, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want %h", got, exp);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got %b want 0", err);
        end
    endtask

    // Expects aresetn low on entry; releases it and checks the lock timeline
    task automatic test_power_on;
        logic [20:0] got, exp;
        logic oe_e, bp_e, hold_e, busy_e, done_e;
        int t_rls;
        t_rls = LOCK + GATE + RSTC;
        @(negedge clk);
        aresetn = 1'b1;
        for (int k = 1; k <= t_rls + 8; k++) begin
            @(negedge clk);
            bp_e   = (k < LOCK);
            oe_e   = (k >= LOCK + GATE);
            hold_e = (k >= t_rls);
            busy_e = (k < t_rls);
            done_e = (k == t_rls);
            got = {pll_mul, pll_div, pll_oe, pll_bp, rst_hold_n, busy, done};
            exp = {8'd46, 8'h22, oe_e, bp_e, hold_e, busy_e, done_e};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL power_on cycle %0d: got %h want %h", k, got, exp);
            end
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL power_on_err: got %b want 0", err);
        end
        m_app = DEF_CFG;
        m_rej = '0;
        m_rej_vld = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_full_seq;
        logic [20:0] got, exp;
        logic [7:0] mul_e;
        logic oe_e, bp_e, hold_e, busy_e, done_e;
        int l0, d0, g;
        l0 = low_cnt;
        d0 = done_cnt;
        @(negedge clk);
        cfg_mul = 8'd60;
        for (int k = 1; k <= T_DETECT + G_RLS + 4; k++) begin
            @(negedge clk);
            g = k - T_DETECT;
            busy_e = (g >= 0) && (g < G_RLS);
            hold_e = !busy_e;
            done_e = (g == G_RLS);
            oe_e   = !((g >= 0) && (g < G_UNGATE));
            bp_e   = (g >= G_BYP) && (g < G_UNBYP);
            mul_e  = (g >= G_LOAD) ? 8'd60 : 8'd46;
            got = {pll_mul, pll_div, pll_oe, pll_bp, rst_hold_n, busy, done};
            exp = {mul_e, 8'h22, oe_e, bp_e, hold_e, busy_e, done_e};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL full_seq cycle %0d: got %h want %h", k, got, exp);
            end
        end
        wait_cyc(2);
        n_cmp++;
        if (low_cnt - l0 !== G_RLS) begin
            n_bad++;
            $display("FAIL full_seq_hold_len: got %0d want %0d", low_cnt - l0, G_RLS);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL full_seq_done_cnt: got %0d want 1", done_cnt - d0);
        end
        m_app = {8'd60, 8'h22, 1'b1, 1'b0};
    endtask

    task automatic test_settle_restart;
        int l0, d0, lat;
        // Return to mul=46 first so the 60/21 pair is a fresh change
        set_cfg(DEF_CFG);
        wait_done(T_DETECT + G_RLS + 20, lat);
        wait_cyc(3);
        l0 = low_cnt;
        d0 = done_cnt;
        cfg_mul = 8'd60;
        wait_cyc(10);
        cfg_div = 8'h21;
        wait_hold_low(60, lat);
        n_cmp++;
        if (lat !== T_DETECT) begin
            n_bad++;
            $display("FAIL settle_restart_latency: got %0d want %0d", lat, T_DETECT);
        end
        wait_done(G_RLS + 10, lat);
        n_cmp++;
        if (lat == -1 || {pll_mul, pll_div} !== {8'd60, 8'h21}) begin
            n_bad++;
            $display("FAIL settle_restart_result: got %h%h lat %0d want 3c21", pll_mul, pll_div, lat);
        end
        wait_cyc(40);
        n_cmp++;
        if (low_cnt - l0 !== G_RLS || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL settle_restart_one_seq: hold %0d done %0d want %0d 1",
                     low_cnt - l0, done_cnt - d0, G_RLS);
        end
        m_app = {8'd60, 8'h21, 1'b1, 1'b0};
    endtask

    task automatic test_reject;
        int l0, d0, lat;
        l0 = low_cnt;
        d0 = done_cnt;
        cfg_div = 8'h20;
        wait_cyc(40);
        n_cmp++;
        if (err !== 1'b1 || {pll_mul, pll_div, pll_oe, pll_bp} !== {m_app}) begin
            n_bad++;
            $display("FAIL reject_flag: err %b outs %h want err 1 outs %h",
                     err, {pll_mul, pll_div, pll_oe, pll_bp}, m_app);
        end
        wait_cyc(100);
        n_cmp++;
        if (low_cnt - l0 !== 0 || done_cnt - d0 !== 0 || busy !== 1'b0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL reject_no_restart: hold %0d done %0d busy %b err %b want 0 0 0 1",
                     low_cnt - l0, done_cnt - d0, busy, err);
        end
        cfg_div = 8'h22;
        cfg_mul = 8'd50;
        wait_hold_low(40, lat);
        n_cmp++;
        if (lat == -1 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL reject_err_kept_mid_seq: lat %0d err %b want err 1", lat, err);
        end
        wait_done(G_RLS + 10, lat);
        n_cmp++;
        if (lat == -1 || err !== 1'b0 || {pll_mul, pll_div} !== {8'd50, 8'h22}) begin
            n_bad++;
            $display("FAIL reject_recover: lat %0d err %b outs %h%h want err 0 3222",
                     lat, err, pll_mul, pll_div);
        end
        wait_cyc(3);
        m_app = {8'd50, 8'h22, 1'b1, 1'b0};
        m_rej_vld = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_oe_only;
        int l0, lat;
        l0 = low_cnt;
        cfg_oe = 1'b0;
        wait_done(60, lat);
        n_cmp++;
        if (lat !== T_DETECT + 1) begin
            n_bad++;
            $display("FAIL oe_only_latency: got %0d want %0d", lat, T_DETECT + 1);
        end
        n_cmp++;
        if ({pll_oe, pll_bp, rst_hold_n, busy} !== 4'b0010) begin
            n_bad++;
            $display("FAIL oe_only_outs: got oe%b bp%b hold%b busy%b want 0 0 1 0",
                     pll_oe, pll_bp, rst_hold_n, busy);
        end
        wait_cyc(3);
        n_cmp++;
        if (low_cnt - l0 !== 0) begin
            n_bad++;
            $display("FAIL oe_only_no_hold: got %0d want 0", low_cnt - l0);
        end
        m_app = {8'd50, 8'h22, 1'b0, 1'b0};
    endtask

    task automatic test_busy_ignore;
        int lat;
        cfg_mul = 8'd60;
        wait_hold_low(40, lat);
        n_cmp++;
        if (lat !== T_DETECT) begin
            n_bad++;
            $display("FAIL busy_ignore_start: got %0d want %0d", lat, T_DETECT);
        end
        wait_cyc(50);
        cfg_mul = 8'd70;
        wait_done(G_RLS + 10, lat);
        n_cmp++;
        if (lat == -1 || pll_mul !== 8'd60) begin
            n_bad++;
            $display("FAIL busy_ignore_first: lat %0d mul %0d want mul 60", lat, pll_mul);
        end
        wait_done(T_DETECT + G_RLS + 10, lat);
        n_cmp++;
        if (lat == -1 || pll_mul !== 8'd70 || pll_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_second: lat %0d mul %0d oe %b want mul 70 oe 0",
                     lat, pll_mul, pll_oe);
        end
        wait_cyc(3);
        m_app = {8'd70, 8'h22, 1'b0, 1'b0};
    endtask

    task automatic test_reset_mid_lock;
        int lat;
        cfg_mul = 8'd80;
        wait_hold_low(40, lat);
        wait_cyc(40);
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({pll_mul, pll_div, pll_bp, rst_hold_n, busy} !== {8'd46, 8'h22, 3'b101}) begin
            n_bad++;
            $display("FAIL reset_mid_lock: got mul %0d div %h bp%b hold%b busy%b want 46 22 1 0 1",
                     pll_mul, pll_div, pll_bp, rst_hold_n, busy);
        end
        set_cfg(DEF_CFG);
        wait_cyc(2);
        test_power_on();
        wait_cyc(40);
        n_cmp++;
        if ({pll_mul, pll_div, pll_oe, pll_bp, rst_hold_n, busy} !== {DEF_CFG, 2'b10}) begin
            n_bad++;
            $display("FAIL reset_mid_lock_idle: got %h want %h",
                     {pll_mul, pll_div, pll_oe, pll_bp, rst_hold_n, busy}, {DEF_CFG, 2'b10});
        end
    endtask

    // 0: nothing happens, 1: rejected, 2: oe/bp-only apply, 3: full sequence
    function automatic int classify(input logic [17:0] r);
        if (r == m_app) return 0;
        if (m_rej_vld && r == m_rej) return 0;
        if (r[6:2] == 5'd0 || r[17:10] < 8'd8) return 1;
        if (r[17:2] == m_app[17:2]) return 2;
        return 3;
    endfunction

    task automatic test_random;
        logic [17:0] req, glitch;
        logic [7:0] vm, vd;
        int cls, l0, d0, exp_low, exp_done;
        for (int it = 0; it < 24; it++) begin
            vm = 8'($urandom_range(8, 255));
            vd = {3'($urandom_range(0, 7)), 5'($urandom_range(1, 31))};
            case ($urandom_range(0, 4))
                0: req = {8'($urandom_range(0, 7)), vd, 2'($urandom_range(0, 3))};
                1: req = {vm, 3'($urandom_range(0, 7)), 5'd0, 2'($urandom_range(0, 3))};
                2: req = m_app ^ {16'd0, 2'($urandom_range(1, 3))};
                3: req = {vm, vd, 2'($urandom_range(0, 3))};
                default: req = m_app;
            endcase
            cls = classify(req);
            exp_low  = (cls == 3) ? G_RLS : 0;
            exp_done = (cls >= 2) ? 1 : 0;
            l0 = low_cnt;
            d0 = done_cnt;
            if ($urandom_range(0, 1) == 1) begin
                glitch = 18'($urandom());
                set_cfg(glitch);
                wait_cyc($urandom_range(1, SETTLE - 2));
            end
            set_cfg(req);
            wait_cyc(200);
            if (cls == 1) begin
                m_rej = req;
                m_rej_vld = 1'b1;
                m_err = 1'b1;
            end else if (cls >= 2) begin
                m_app = req;
                m_rej_vld = 1'b0;
                m_err = 1'b0;
            end
            n_cmp++;
            if ({pll_mul, pll_div, pll_oe, pll_bp} !== m_app || err !== m_err) begin
                n_bad++;
                $display("FAIL random_state it %0d: outs %h err %b want %h err %b",
                         it, {pll_mul, pll_div, pll_oe, pll_bp}, err, m_app, m_err);
            end
            n_cmp++;
            if (low_cnt - l0 !== exp_low || done_cnt - d0 !== exp_done ||
                rst_hold_n !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL random_activity it %0d: hold %0d done %0d want %0d %0d",
                         it, low_cnt - l0, done_cnt - d0, exp_low, exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_full_seq();
        test_settle_restart();
        test_reject();
        test_oe_only();
        test_busy_ignore();
        test_reset_mid_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Sequences safe runtime reconfiguration of one S018PLLGS_LC PLL (CPU or SoC) from the I2C-controller configuration bytes. It runs in the 25 MHz reference domain. It waits for a new MUL/DIV/OE/BP setting to settle, validates it, then steps the PLL through gate -> bypass -> load -> lock-wait -> unbypass -> ungate. It holds the downstream clock-domain reset the whole time. One instance is used per PLL; rst_hold_n is ANDed into the source of that domain's reset synchroniser.

Parameters:
DEF_MUL, 8'd46, PLL M value at reset
DEF_DIV, 8'h22, {OD[2:0],N[4:0]} at reset
DEF_OE, 1'b1, OE value applied after the power-on lock
DEF_BP, 1'b0, BP value applied after the power-on lock
M_MIN, 8'd8, smallest legal M
SETTLE_CYC, 256, cycles cfg_* must stay stable before acting
GATE_CYC, 16, duration of the GATE, BYP and UNBYP steps
LOCK_CYC, 12500, lock wait (500 us at 25 MHz)
RST_CYC, 64, reset hold after ungate
CNT_W, 16, counter width; must cover max(all *_CYC)

Ports:
clk  in  1  25 MHz reference clock
aresetn  in  1  asynchronous active-low reset
cfg_mul  in  8  requested M (from I2C register)
cfg_div  in  8  requested {OD,N}
cfg_oe  in  1  requested OE
cfg_bp  in  1  requested BP
pll_mul  out  8  M to PLL
pll_div  out  8  {OD,N} to PLL
pll_oe  out  1  PLL OE
pll_bp  out  1  PLL BP
rst_hold_n  out  1  0 = hold downstream domain in reset
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a sequence completes
err  out  1  sticky: last request rejected

Behaviour:
Outputs and reset state
- All outputs are registered.
- An "applied" shadow {mul,div,oe,bp} drives the pll_* outputs while in IDLE.

Async reset
- pll_mul=DEF_MUL, pll_div=DEF_DIV, pll_oe=0, pll_bp=1, rst_hold_n=0, busy=1, done=0, err=0.
- State = LOCK, counter = 0, target oe/bp = DEF_OE/DEF_BP. This gives the power-on lock wait.

State timing
- Each timed state lasts exactly its *_CYC cycles; the counter resets on every state entry.

States
- IDLE: busy=0, rst_hold_n=1. Moves to SETTLE when cfg_* != applied and cfg_* != rejected snapshot.
- SETTLE: counts while cfg_* is unchanged from the previous cycle; any change restarts the count.
  - Leaving SETTLE, evaluated in order:
  - cfg_* == applied -> IDLE, silently.
  - N==0 or cfg_mul<M_MIN -> latch cfg_* into the rejected snapshot, set err, go to IDLE. Outputs are unchanged.
  - Only oe/bp differ -> APPLY.
  - Otherwise -> latch target, busy=1, go to GATE.
- APPLY (1 cycle): pll_oe/pll_bp <= target, update applied, done pulse, clear err, go to IDLE. No reset hold and no bypass in this path.
- GATE (GATE_CYC): pll_oe=0, rst_hold_n=0.
- BYP (GATE_CYC): pll_bp=1.
- LOAD (1 cycle): pll_mul/pll_div <= target.
- LOCK (LOCK_CYC): no output change.
- UNBYP (GATE_CYC): pll_bp <= target bp.
- UNGATE (RST_CYC): pll_oe <= target oe.
- RLS (1 cycle): rst_hold_n=1, done=1, applied <= target, err=0, busy=0, go to IDLE.

Requests during a sequence
- cfg_* changes while busy are ignored until IDLE is reached. IDLE then re-detects the difference, so the latest value always wins.
- An err that is already set is not cleared by a later rejected request.
- The rejected snapshot is cleared on any successful APPLY/RLS.

Reset mid-sequence
- Async reset aborts immediately to the reset state.
- The applied shadow reverts to DEF_*.

Test Plan:
Use LOCK_CYC=100, GATE_CYC=4, RST_CYC=8, SETTLE_CYC=16, and cfg held at the defaults.

1. Power-on: release aresetn.
   -> pll_oe=0 and pll_bp=1 for 100 cycles.
   -> pll_bp=0 at cycle 100; pll_oe=1 at cycle 104.
   -> rst_hold_n=1 and done pulse at cycle 112; busy=0 afterwards.
2. Write cfg_mul=60 in IDLE.
   -> After 16 stable cycles, busy=1 and pll_oe=0 and rst_hold_n=0.
   -> pll_bp=1 after 4 cycles, pll_mul=60 after 4 more, lock for 100 cycles.
   -> Ungate, then rst_hold_n=1 and done pulse 8 cycles later. Total hold = 4+4+1+100+4+8 = 121 cycles.
3. Write cfg_mul=60, then cfg_div=8'h21 ten cycles later.
   -> Settle count restarts; exactly one sequence runs, with pll_mul=60 and pll_div=8'h21.
4. Write cfg_div=8'h20 (N=0).
   -> err=1, no output change, no restart while cfg stays the same.
   -> Then write a valid cfg_div=8'h22 with cfg_mul=50: sequence runs and err clears at RLS.
5. cfg_oe toggles 1->0 only.
   -> After settle, pll_oe=0 next cycle with a done pulse; rst_hold_n stays 1 and pll_bp stays 0.
6. Change cfg_mul=70 during LOCK of a mul=60 sequence.
   -> The first sequence completes with mul=60; a second sequence starts after 16 settle cycles and ends with pll_mul=70.
   -> Assert aresetn mid-LOCK: pll_mul returns to 46 immediately and the power-on timeline of scenario 1 repeats.
